bbuf_ctrl: RTL and testbench
============================

# bbuf_ctrl

Sequencer for the bias buffer. It turns a valid/ready stream of memory words from the load engine into bias-buffer write requests with incrementing addresses. It issues the read-address sequence the systolic array consumes per output tile, and it interlocks reads against an in-flight load. It sits between the memory interface, the bias buffer and the compute controller.

## Interface
Parameters:
- MEM_DATA_WIDTH, 64, width of one load beat / buffer write word
- MEM_ADDR_WIDTH, 11, buffer write-side address width
- BUF_ADDR_WIDTH, 10, buffer read-side address width
- LOOP_W, 16, width of all count/repeat fields
- READ_LATENCY, 2, cycles from buf_read_req to bias data at the buffer output

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_load_start  in  1  one-cycle pulse; latch load config
- cfg_load_base  in  MEM_ADDR_WIDTH  first write address
- cfg_load_words  in  LOOP_W  beats to write
- ld_data_valid  in  1  load beat valid
- ld_data  in  MEM_DATA_WIDTH  load beat
- ld_data_ready  out  1  beat accepted when valid&ready
- mem_write_req  out  1  buffer write strobe
- mem_write_addr  out  MEM_ADDR_WIDTH  buffer write address
- mem_write_data  out  MEM_DATA_WIDTH  buffer write data
- load_busy  out  1  load in progress
- load_done  out  1  one-cycle pulse after last write
- cfg_rd_start  in  1  one-cycle pulse; latch read config
- cfg_rd_base  in  BUF_ADDR_WIDTH  first read address
- cfg_rd_count  in  LOOP_W  reads per pass
- cfg_rd_repeat  in  LOOP_W  number of passes
- rd_stall  in  1  consumer back-pressure; freezes read issue
- buf_read_req  out  1  buffer read strobe
- buf_read_addr  out  BUF_ADDR_WIDTH  buffer read address
- bias_valid  out  1  buf_read_req delayed READ_LATENCY cycles
- rd_busy  out  1  read sequence pending or active
- rd_done  out  1  one-cycle pulse after last read issued

## Operation
- Load FSM LD_IDLE -> LD_ACTIVE -> LD_IDLE.
  - cfg_load_start in LD_IDLE latches base and count.
  - count 0 -> load_done next cycle and remain in IDLE.
  - cfg_load_start while not IDLE is ignored.
- ld_data_ready = (state == LD_ACTIVE).
  - Each accepted beat registers mem_write_req=1, the current address, and the data.
  - Address increments mod 2^MEM_ADDR_WIDTH; wrap is silent.
  - The last beat moves the FSM to IDLE. load_done fires in the same cycle as the final mem_write_req.
- Read FSM RD_IDLE -> RD_WAIT -> RD_ISSUE -> RD_IDLE.
  - cfg_rd_start in RD_IDLE latches config.
  - Goes to RD_WAIT if load_busy or cfg_load_start is asserted that cycle, else RD_ISSUE.
  - RD_WAIT leaves one cycle after load_done.
  - count 0 or repeat 0 -> rd_done next cycle, no reads.
- RD_ISSUE, each non-stalled cycle:
  - buf_read_req=1 with the current address.
  - Address increments mod 2^BUF_ADDR_WIDTH.
  - After cfg_rd_count reads the address reloads cfg_rd_base and the pass counter increments.
  - After cfg_rd_repeat passes -> RD_IDLE with rd_done.
- rd_stall=1: buf_read_req=0; address and counters hold.
- cfg_rd_start while not IDLE is ignored.
- Load and read FSMs are independent apart from the RD_WAIT interlock. A load may start while reads issue; the compute controller owns that hazard.
- bias_valid is a READ_LATENCY-deep shift of buf_read_req, cleared by reset.

## Timing
- Reset value of every output is 0, including the address and data registers. Reset mid-operation aborts both FSMs to IDLE and flushes the bias_valid pipe.
- Write latency: beat accepted in cycle t -> mem_write_req in cycle t+1. Full throughput is one beat per cycle.
- Read: cfg_rd_start at t, no wait -> first buf_read_req at t+1.
  - Total cycles = count*repeat + stall cycles.
  - rd_done coincides with the last buf_read_req.
- load_busy is high from the cycle after cfg_load_start until load_done. rd_busy is defined the same way for reads.

## Structure
- Shared package: FSM state encodings (LD_IDLE/LD_ACTIVE, RD_IDLE/RD_WAIT/RD_ISSUE).
- One sub-module, bbuf_rd_addr_gen: base/count/repeat address counter with stall.
- Load FSM and interlock stay in the top module.

## Test plan
- Load base=0x7FE, words=4, valid held high -> writes to 0x7FE, 0x7FF, 0x000, 0x001 on consecutive cycles; load_done with the 4th write.
- Load words=3 with valid toggling 1,0,1,0,1 -> exactly 3 writes in beat order; ready low after the last beat.
- Read base=5, count=3, repeat=2 -> addresses 5,6,7,5,6,7 back-to-back; rd_done with the 6th; bias_valid mirrors req 2 cycles later.
- rd_stall high for 2 cycles mid-pass -> req low for 2 cycles, sequence resumes unchanged, total 8 cycles.
- cfg_rd_start while a 4-beat load is active -> no buf_read_req until the cycle after load_done.
- Reset asserted mid-read -> all outputs 0 immediately; a new cfg_rd_start after release restarts from cfg_rd_base.

Source files
------------

// File: rtl/bbuf_ctrl_pkg.sv
// Shared state encodings for the bias-buffer sequencer.
package bbuf_ctrl_pkg;

  typedef enum logic {
    LD_IDLE   = 1'b0,
    LD_ACTIVE = 1'b1
  } ld_state_e;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_WAIT  = 2'd1,
    RD_ISSUE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/bbuf_rd_addr_gen.sv
// Read-address generator: walks base..base+count-1, repeated 'repeat' times.
// The address only moves on cycles where a read is actually issued.
module bbuf_rd_addr_gen
  import bbuf_ctrl_pkg::*;
#(
  parameter int BUF_ADDR_WIDTH = 10,
  parameter int LOOP_W         = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [BUF_ADDR_WIDTH-1:0] base_i,
  input  logic [LOOP_W-1:0]         count_i,
  input  logic [LOOP_W-1:0]         repeat_i,
  input  logic                      advance_i,
  output logic [BUF_ADDR_WIDTH-1:0] addr_o,
  output logic                      last_o
);

  logic [BUF_ADDR_WIDTH-1:0] base_q, addr_q, addr_d;
  logic [LOOP_W-1:0]         count_q, repeat_q;
  logic [LOOP_W-1:0]         idx_q, idx_d, pass_q, pass_d;
  logic                      end_of_pass;

  assign end_of_pass = (idx_q == count_q - LOOP_W'(1));
  assign last_o      = end_of_pass && (pass_q == repeat_q - LOOP_W'(1));
  assign addr_o      = addr_q;

  // Next address / position: reload base at the end of each pass.
  always_comb begin
    addr_d = addr_q;
    idx_d  = idx_q;
    pass_d = pass_q;
    if (start_i) begin
      addr_d = base_i;
      idx_d  = '0;
      pass_d = '0;
    end else if (advance_i) begin
      if (end_of_pass) begin
        addr_d = base_q;
        idx_d  = '0;
        pass_d = pass_q + LOOP_W'(1);
      end else begin
        addr_d = addr_q + BUF_ADDR_WIDTH'(1);
        idx_d  = idx_q + LOOP_W'(1);
      end
    end
  end

  // Counter state and latched configuration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      count_q  <= '0;
      repeat_q <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      pass_q   <= '0;
    end else begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
      pass_q <= pass_d;
      if (start_i) begin
        base_q   <= base_i;
        count_q  <= count_i;
        repeat_q <= repeat_i;
      end
    end
  end

endmodule

// File: rtl/bbuf_ctrl.sv
// Bias-buffer sequencer: load stream -> buffer writes, and per-tile read
// sequence generation with an interlock that holds reads behind a load.
module bbuf_ctrl
  import bbuf_ctrl_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = 64,
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int BUF_ADDR_WIDTH = 10,
  parameter int LOOP_W         = 16,
  parameter int READ_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_load_start,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_load_base,
  input  logic [LOOP_W-1:0]         cfg_load_words,
  input  logic                      ld_data_valid,
  input  logic [MEM_DATA_WIDTH-1:0] ld_data,
  output logic                      ld_data_ready,
  output logic                      mem_write_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_write_data,
  output logic                      load_busy,
  output logic                      load_done,
  input  logic                      cfg_rd_start,
  input  logic [BUF_ADDR_WIDTH-1:0] cfg_rd_base,
  input  logic [LOOP_W-1:0]         cfg_rd_count,
  input  logic [LOOP_W-1:0]         cfg_rd_repeat,
  input  logic                      rd_stall,
  output logic                      buf_read_req,
  output logic [BUF_ADDR_WIDTH-1:0] buf_read_addr,
  output logic                      bias_valid,
  output logic                      rd_busy,
  output logic                      rd_done
);

  ld_state_e                 ld_state_q;
  logic [MEM_ADDR_WIDTH-1:0] ld_addr_q;
  logic [LOOP_W-1:0]         ld_left_q;
  logic                      wr_req_q;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_q;
  logic [MEM_DATA_WIDTH-1:0] wr_data_q;
  logic                      load_done_q;

  rd_state_e                 rd_state_q;
  logic                      rd_zero_done_q;
  logic                      rd_gen_start;
  logic                      rd_gen_last;
  logic                      rd_cfg_empty;
  logic [READ_LATENCY-1:0]   bias_pipe_q;

  assign ld_data_ready  = (ld_state_q == LD_ACTIVE);
  assign load_busy      = (ld_state_q == LD_ACTIVE);
  assign mem_write_req  = wr_req_q;
  assign mem_write_addr = wr_addr_q;
  assign mem_write_data = wr_data_q;
  assign load_done      = load_done_q;

  // Load FSM: latch config, then turn each accepted beat into a registered write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state_q  <= LD_IDLE;
      ld_addr_q   <= '0;
      ld_left_q   <= '0;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      load_done_q <= 1'b0;
    end else begin
      wr_req_q    <= 1'b0;
      load_done_q <= 1'b0;
      case (ld_state_q)
        LD_IDLE: begin
          if (cfg_load_start) begin
            if (cfg_load_words == '0) begin
              load_done_q <= 1'b1;
            end else begin
              ld_state_q <= LD_ACTIVE;
              ld_addr_q  <= cfg_load_base;
              ld_left_q  <= cfg_load_words;
            end
          end
        end
        LD_ACTIVE: begin
          if (ld_data_valid) begin
            wr_req_q  <= 1'b1;
            wr_addr_q <= ld_addr_q;
            wr_data_q <= ld_data;
            ld_addr_q <= ld_addr_q + MEM_ADDR_WIDTH'(1);
            ld_left_q <= ld_left_q - LOOP_W'(1);
            if (ld_left_q == LOOP_W'(1)) begin
              ld_state_q  <= LD_IDLE;
              load_done_q <= 1'b1;
            end
          end
        end
        default: ld_state_q <= LD_IDLE;
      endcase
    end
  end

  // Read issue is gated by stall in the same cycle so a stalled slot never fires.
  assign rd_cfg_empty  = (cfg_rd_count == '0) || (cfg_rd_repeat == '0);
  assign rd_gen_start  = (rd_state_q == RD_IDLE) && cfg_rd_start;
  assign buf_read_req  = (rd_state_q == RD_ISSUE) && !rd_stall;
  assign rd_done       = rd_zero_done_q || (buf_read_req && rd_gen_last);
  assign rd_busy       = (rd_state_q != RD_IDLE);

  bbuf_rd_addr_gen #(
    .BUF_ADDR_WIDTH (BUF_ADDR_WIDTH),
    .LOOP_W         (LOOP_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .start_i   (rd_gen_start),
    .base_i    (cfg_rd_base),
    .count_i   (cfg_rd_count),
    .repeat_i  (cfg_rd_repeat),
    .advance_i (buf_read_req),
    .addr_o    (buf_read_addr),
    .last_o    (rd_gen_last)
  );

  // Read FSM: hold in WAIT while a load is in flight, then issue until the last read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q     <= RD_IDLE;
      rd_zero_done_q <= 1'b0;
    end else begin
      rd_zero_done_q <= 1'b0;
      case (rd_state_q)
        RD_IDLE: begin
          if (cfg_rd_start) begin
            if (rd_cfg_empty) begin
              rd_zero_done_q <= 1'b1;
            end else if (load_busy || cfg_load_start) begin
              rd_state_q <= RD_WAIT;
            end else begin
              rd_state_q <= RD_ISSUE;
            end
          end
        end
        RD_WAIT: begin
          if (load_done_q) rd_state_q <= RD_ISSUE;
        end
        RD_ISSUE: begin
          if (buf_read_req && rd_gen_last) rd_state_q <= RD_IDLE;
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // bias_valid tracks buf_read_req through the buffer's read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bias_pipe_q <= '0;
    end else begin
      bias_pipe_q[0] <= buf_read_req;
      for (int i = 1; i < READ_LATENCY; i++) bias_pipe_q[i] <= bias_pipe_q[i-1];
    end
  end

  assign bias_valid = bias_pipe_q[READ_LATENCY-1];

endmodule

// File: tb/tb_bbuf_ctrl.sv
// Self-checking bench for bbuf_ctrl: directed scenarios plus random traffic,
// all checked every cycle against a queue-based reference model.
module tb_bbuf_ctrl;

  localparam int DW = 64;
  localparam int AW = 11;
  localparam int BW = 10;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_load_start;
  logic [AW-1:0] cfg_load_base;
  logic [LW-1:0] cfg_load_words;
  logic          ld_data_valid;
  logic [DW-1:0] ld_data;
  logic          ld_data_ready;
  logic          mem_write_req;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic          load_busy;
  logic          load_done;
  logic          cfg_rd_start;
  logic [BW-1:0] cfg_rd_base;
  logic [LW-1:0] cfg_rd_count;
  logic [LW-1:0] cfg_rd_repeat;
  logic          rd_stall;
  logic          buf_read_req;
  logic [BW-1:0] buf_read_addr;
  logic          bias_valid;
  logic          rd_busy;
  logic          rd_done;

  bbuf_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_load_start (cfg_load_start),
    .cfg_load_base  (cfg_load_base),
    .cfg_load_words (cfg_load_words),
    .ld_data_valid  (ld_data_valid),
    .ld_data        (ld_data),
    .ld_data_ready  (ld_data_ready),
    .mem_write_req  (mem_write_req),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .cfg_rd_start   (cfg_rd_start),
    .cfg_rd_base    (cfg_rd_base),
    .cfg_rd_count   (cfg_rd_count),
    .cfg_rd_repeat  (cfg_rd_repeat),
    .rd_stall       (rd_stall),
    .buf_read_req   (buf_read_req),
    .buf_read_addr  (buf_read_addr),
    .bias_valid     (bias_valid),
    .rd_busy        (rd_busy),
    .rd_done        (rd_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  int            m_ld_left;
  int            m_ld_addr;
  bit            m_ld_zero;
  bit            m_wr_pend;
  bit            m_wr_last;
  int            m_wr_addr;
  logic [DW-1:0] m_wr_data;
  int            m_rd_q[$];
  bit            m_rd_wait;
  bit            m_rd_zero;
  bit            m_h0, m_h1;

  // Observation records for scenario-level checks
  int obs_wr[$];
  int obs_rd[$];
  int ld_done_cyc, rd_done_cyc, first_req_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_wr.delete();
    obs_rd.delete();
    ld_done_cyc   = -1;
    rd_done_cyc   = -1;
    first_req_cyc = -1;
  endtask

  task automatic idle_inputs();
    cfg_load_start = 1'b0;
    cfg_load_base  = '0;
    cfg_load_words = '0;
    ld_data_valid  = 1'b0;
    ld_data        = '0;
    cfg_rd_start   = 1'b0;
    cfg_rd_base    = '0;
    cfg_rd_count   = '0;
    cfg_rd_repeat  = '0;
    rd_stall       = 1'b0;
  endtask

  // Assert reset away from the clock edge and check every output is 0 at once.
  task automatic apply_reset();
    reset = 1'b1;
    #2;
    chk("rst_ready",     {63'd0, ld_data_ready}, 64'd0);
    chk("rst_wreq",      {63'd0, mem_write_req}, 64'd0);
    chk("rst_waddr",     64'(mem_write_addr), 64'd0);
    chk("rst_wdata",     mem_write_data, 64'd0);
    chk("rst_ld_busy",   {63'd0, load_busy}, 64'd0);
    chk("rst_ld_done",   {63'd0, load_done}, 64'd0);
    chk("rst_rreq",      {63'd0, buf_read_req}, 64'd0);
    chk("rst_raddr",     64'(buf_read_addr), 64'd0);
    chk("rst_bias_vld",  {63'd0, bias_valid}, 64'd0);
    chk("rst_rd_busy",   {63'd0, rd_busy}, 64'd0);
    chk("rst_rd_done",   {63'd0, rd_done}, 64'd0);
    idle_inputs();
    m_ld_left = 0; m_ld_addr = 0; m_ld_zero = 0;
    m_wr_pend = 0; m_wr_last = 0; m_wr_addr = 0; m_wr_data = '0;
    m_rd_q.delete(); m_rd_wait = 0; m_rd_zero = 0;
    m_h0 = 0; m_h1 = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle: inputs are already driven; check at negedge, advance model.
  task automatic tick();
    bit e_rdy, e_wreq, e_ldone, e_lbusy, e_req, e_rdone, e_rbusy, e_bv, rd_idle;
    @(negedge clk);
    cyc++;
    e_rdy   = (m_ld_left > 0);
    e_lbusy = (m_ld_left > 0);
    e_wreq  = m_wr_pend;
    e_ldone = (m_wr_pend && m_wr_last) || m_ld_zero;
    rd_idle = (m_rd_q.size() == 0);
    e_rbusy = !rd_idle;
    e_req   = !rd_idle && !m_rd_wait && !rd_stall;
    e_rdone = (e_req && m_rd_q.size() == 1) || m_rd_zero;
    e_bv    = m_h1;

    chk("ld_data_ready", {63'd0, ld_data_ready}, {63'd0, e_rdy});
    chk("load_busy",     {63'd0, load_busy},     {63'd0, e_lbusy});
    chk("mem_write_req", {63'd0, mem_write_req}, {63'd0, e_wreq});
    chk("load_done",     {63'd0, load_done},     {63'd0, e_ldone});
    chk("buf_read_req",  {63'd0, buf_read_req},  {63'd0, e_req});
    chk("rd_done",       {63'd0, rd_done},       {63'd0, e_rdone});
    chk("rd_busy",       {63'd0, rd_busy},       {63'd0, e_rbusy});
    chk("bias_valid",    {63'd0, bias_valid},    {63'd0, e_bv});
    if (e_wreq) begin
      chk("mem_write_addr", 64'(mem_write_addr), 64'(m_wr_addr));
      chk("mem_write_data", mem_write_data, m_wr_data);
    end
    if (e_req) chk("buf_read_addr", 64'(buf_read_addr), 64'(m_rd_q[0]));

    if (mem_write_req) obs_wr.push_back(int'(mem_write_addr));
    if (load_done) ld_done_cyc = cyc;
    if (rd_done) rd_done_cyc = cyc;
    if (buf_read_req) begin
      obs_rd.push_back(int'(buf_read_addr));
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end

    // Load side of the model
    if (e_rdy && ld_data_valid) begin
      m_wr_pend = 1;
      m_wr_addr = m_ld_addr;
      m_wr_data = ld_data;
      m_wr_last = (m_ld_left == 1);
      m_ld_left--;
      m_ld_addr = (m_ld_addr + 1) % (1 << AW);
    end else begin
      m_wr_pend = 0;
    end
    m_ld_zero = 0;
    if (!e_rdy && cfg_load_start) begin
      if (cfg_load_words == 0) m_ld_zero = 1;
      else begin
        m_ld_left = int'(cfg_load_words);
        m_ld_addr = int'(cfg_load_base);
      end
    end

    // Read side of the model: the full address list is precomputed at start
    if (m_rd_wait && e_ldone) m_rd_wait = 0;
    if (e_req) void'(m_rd_q.pop_front());
    m_rd_zero = 0;
    if (rd_idle && cfg_rd_start) begin
      if (cfg_rd_count == 0 || cfg_rd_repeat == 0) m_rd_zero = 1;
      else begin
        for (int p = 0; p < int'(cfg_rd_repeat); p++)
          for (int k = 0; k < int'(cfg_rd_count); k++)
            m_rd_q.push_back((int'(cfg_rd_base) + k) % (1 << BW));
        m_rd_wait = e_lbusy || cfg_load_start;
      end
    end
    m_h1 = m_h0;
    m_h0 = e_req;

    @(posedge clk);
    #1;
  endtask

  int s;
  int exp_wr1[4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
  int exp_rd3[6] = '{5, 6, 7, 5, 6, 7};

  initial begin
    idle_inputs();
    apply_reset();

    // Load with address wrap, valid held high
    clear_obs();
    cfg_load_base = 11'h7FE; cfg_load_words = 16'd4; cfg_load_start = 1'b1;
    ld_data_valid = 1'b1; ld_data = 64'hA5A5_0000_0000_0000;
    s = cyc + 1;
    tick();
    cfg_load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ld_data = 64'hC0DE_0000_0000_0000 | 64'(i);
      tick();
    end
    ld_data_valid = 1'b0;
    tick();
    chk("s1_nwrites", 64'(obs_wr.size()), 64'd4);
    if (obs_wr.size() == 4)
      for (int i = 0; i < 4; i++) chk("s1_waddr", 64'(obs_wr[i]), 64'(exp_wr1[i]));
    chk("s1_done_cyc", 64'(ld_done_cyc), 64'(s + 5));

    // Load 3 words with valid toggling
    clear_obs();
    cfg_load_base = 11'h010; cfg_load_words = 16'd3; cfg_load_start = 1'b1;
    tick();
    cfg_load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_data_valid = (i < 5) && ((i % 2) == 0);
      ld_data = 64'h1111_2222_3333_0000 | 64'(i);
      tick();
    end
    chk("s2_nwrites", 64'(obs_wr.size()), 64'd3);

    // Read base=5 count=3 repeat=2, no stall
    clear_obs();
    cfg_rd_base = 10'd5; cfg_rd_count = 16'd3; cfg_rd_repeat = 16'd2; cfg_rd_start = 1'b1;
    s = cyc + 1;
    tick();
    cfg_rd_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("s3_nreads", 64'(obs_rd.size()), 64'd6);
    if (obs_rd.size() == 6)
      for (int i = 0; i < 6; i++) chk("s3_raddr", 64'(obs_rd[i]), 64'(exp_rd3[i]));
    chk("s3_first_req", 64'(first_req_cyc), 64'(s + 1));
    chk("s3_done_cyc", 64'(rd_done_cyc), 64'(s + 6));

    // Same read with a two-cycle stall mid-pass
    clear_obs();
    cfg_rd_start = 1'b1;
    s = cyc + 1;
    tick();
    cfg_rd_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      rd_stall = (i == 3) || (i == 4);
      tick();
    end
    rd_stall = 1'b0;
    chk("s4_nreads", 64'(obs_rd.size()), 64'd6);
    if (obs_rd.size() == 6)
      for (int i = 0; i < 6; i++) chk("s4_raddr", 64'(obs_rd[i]), 64'(exp_rd3[i]));
    chk("s4_done_cyc", 64'(rd_done_cyc), 64'(s + 8));

    // Read requested while a 4-beat load is active
    clear_obs();
    cfg_load_base = 11'h100; cfg_load_words = 16'd4; cfg_load_start = 1'b1;
    ld_data_valid = 1'b1; ld_data = 64'h0BAD_F00D_0000_0001;
    s = cyc + 1;
    tick();
    cfg_load_start = 1'b0;
    cfg_rd_base = 10'd20; cfg_rd_count = 16'd2; cfg_rd_repeat = 16'd1; cfg_rd_start = 1'b1;
    tick();
    cfg_rd_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    ld_data_valid = 1'b0;
    chk("s5_ld_done", 64'(ld_done_cyc), 64'(s + 5));
    chk("s5_first_req", 64'(first_req_cyc), 64'(s + 6));

    // Zero-length configurations
    clear_obs();
    cfg_rd_count = 16'd0; cfg_rd_repeat = 16'd3; cfg_rd_start = 1'b1;
    tick();
    cfg_rd_start = 1'b0;
    tick();
    cfg_rd_count = 16'd2; cfg_rd_repeat = 16'd0; cfg_rd_start = 1'b1;
    cfg_load_words = 16'd0; cfg_load_start = 1'b1;
    tick();
    cfg_rd_start = 1'b0; cfg_load_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("s6_no_reads", 64'(obs_rd.size()), 64'd0);
    chk("s6_no_writes", 64'(obs_wr.size()), 64'd0);

    // Reset in the middle of a read, then restart
    cfg_rd_base = 10'd40; cfg_rd_count = 16'd4; cfg_rd_repeat = 16'd3; cfg_rd_start = 1'b1;
    tick();
    cfg_rd_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    apply_reset();
    clear_obs();
    cfg_rd_base = 10'd9; cfg_rd_count = 16'd2; cfg_rd_repeat = 16'd1; cfg_rd_start = 1'b1;
    tick();
    cfg_rd_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("s7_nreads", 64'(obs_rd.size()), 64'd2);
    if (obs_rd.size() > 0) chk("s7_restart_addr", 64'(obs_rd[0]), 64'd9);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      cfg_load_start = ($urandom_range(0, 15) == 0);
      cfg_load_base  = AW'($urandom);
      cfg_load_words = LW'($urandom_range(0, 6));
      ld_data_valid  = ($urandom_range(0, 2) != 0);
      ld_data        = {$urandom, $urandom};
      cfg_rd_start   = ($urandom_range(0, 11) == 0);
      cfg_rd_base    = BW'($urandom);
      cfg_rd_count   = LW'($urandom_range(0, 4));
      cfg_rd_repeat  = LW'($urandom_range(0, 3));
      rd_stall       = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 60; i++) tick();
    chk("end_rd_idle", {63'd0, rd_busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
